// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store sequencer around sizehandlerMUX.
// Holds the op / size-handler select encodings, the sequencer state
// encoding and a small op classification helper.
package mem_access_ctrl_pkg;

    // The op code from the control unit doubles as the size-handler select.
    localparam logic [2:0] SEL_SB  = 3'b000;
    localparam logic [2:0] SEL_SW  = 3'b001;
    localparam logic [2:0] SEL_SH  = 3'b010;
    localparam logic [2:0] SEL_LB  = 3'b011;
    localparam logic [2:0] SEL_LW  = 3'b100;
    localparam logic [2:0] SEL_LH  = 3'b101;
    localparam logic [2:0] SEL_REP = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    function automatic logic is_load(input logic [2:0] op);
        return (op == SEL_LB) || (op == SEL_LW) || (op == SEL_LH);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request / memory-side bundle of the load/store sequencer.
//   start, op, addr         : request from the control unit
//   busy, done, err         : sequencer status back to the control unit
//   mem_addr, mem_wr        : word address and write enable to memory
//   mdr_load, sh_sel        : MDR capture enable and sizehandlerMUX select
// master = control unit side, slave = sequencer side.
interface mem_access_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic        mdr_load;
    logic [2:0]  sh_sel;

    modport master (
        output start, op, addr,
        input  busy, done, err, mem_addr, mem_wr, mdr_load, sh_sel
    );

    modport slave (
        input  start, op, addr,
        output busy, done, err, mem_addr, mem_wr, mdr_load, sh_sel
    );
endinterface

// File: rtl/mem_access_ctrl_align_check.sv
// Combinational legality decoder for a memory op.
//   op      : op code (size-handler encoding)
//   addr_lo : addr[1:0] of the access
//   legal   : 1 when the op code exists and the address is naturally aligned
// Kept standalone so exception logic can reuse the same decision.
module align_check
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] addr_lo,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        case (op)
            SEL_SB, SEL_LB: legal = 1'b1;
            SEL_SW, SEL_LW: legal = (addr_lo == 2'b00);
            SEL_SH, SEL_LH: legal = ~addr_lo[0];
            default:        legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer in front of sizehandlerMUX.
// Takes one op at a time, reads memory for loads and sub-word stores
// (read-modify-write), writes directly for sw, and flags illegal ops
// without touching memory.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : request/status/memory bundle (slave side)
// Parameters:
//   READ_LAT : memory read latency in cycles (1..15)
//   CNT_W    : latency counter width, must hold READ_LAT
//
// state | meaning
// IDLE  | waiting for start, memory untouched
// RD    | memory read in flight, READ_LAT cycles
// CAP   | load data through the size handler into MDR
// WR    | single write cycle, merged word for sb/sh
// FIN   | done pulse
// ERR   | err pulse for misaligned / unknown op
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    mem_access_ctrl_if.slave bus
);

    state_t            state;
    logic [31:2]       addr_q;    // only the word part ever reaches memory
    logic [2:0]        op_q;
    logic [CNT_W-1:0]  cnt;
    logic              op_legal;

    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              mem_wr_q;
    logic              mdr_load_q;
    logic [2:0]        sh_sel_q;

    align_check u_align_check (
        .op      (bus.op),
        .addr_lo (bus.addr[1:0]),
        .legal   (op_legal)
    );

    // Outputs are registered alongside the state transition, so each
    // state's output values are set on the edge that enters it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            op_q       <= '0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_wr_q   <= 1'b0;
            mdr_load_q <= 1'b0;
            sh_sel_q   <= SEL_REP;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_wr_q   <= 1'b0;
            mdr_load_q <= 1'b0;
            sh_sel_q   <= SEL_REP;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        addr_q <= bus.addr[31:2];
                        busy_q <= 1'b1;
                        if (!op_legal) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else if (bus.op == SEL_SW) begin
                            state    <= WR;
                            mem_wr_q <= 1'b1;
                            sh_sel_q <= SEL_SW;
                        end else begin
                            state <= RD;
                            cnt   <= CNT_W'(READ_LAT - 1);
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        sh_sel_q <= op_q;
                        if (is_load(op_q)) begin
                            state      <= CAP;
                            mdr_load_q <= 1'b1;
                        end else begin
                            // sb/sh: read data is still on the bus for the merge
                            state    <= WR;
                            mem_wr_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CAP, WR: begin
                    state  <= FIN;
                    done_q <= 1'b1;
                end
                FIN, ERR: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mdr_load = mdr_load_q;
    assign bus.sh_sel   = sh_sel_q;
    assign bus.mem_addr = (state == IDLE) ? 32'h0 : {addr_q, 2'b00};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: two instances (READ_LAT=1 and 3)
// share the same request stimulus and are each compared cycle by cycle.
module tb_mem_access_ctrl;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        mem_wr;
        logic        mdr_load;
        logic [2:0]  sh_sel;
        logic [31:0] mem_addr;
    } obs_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic        illegal;
        logic [31:0] word;
    } vec_t;

    localparam int NVEC = 14;
    localparam obs_t RST_OBS = '{busy: 1'b0, done: 1'b0, err: 1'b0, mem_wr: 1'b0,
                                 mdr_load: 1'b0, sh_sel: 3'b111, mem_addr: 32'h0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'h0;

    int n_cmp = 0;
    int n_fail = 0;
    int n_overlap = 0;

    vec_t vecs[NVEC];

    mem_access_ctrl_if bus1 ();
    mem_access_ctrl_if bus3 ();

    assign bus1.start = start;
    assign bus1.op    = op;
    assign bus1.addr  = addr;
    assign bus3.start = start;
    assign bus3.op    = op;
    assign bus3.addr  = addr;

    mem_access_ctrl #(.READ_LAT(1), .CNT_W(4)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_access_ctrl #(.READ_LAT(3), .CNT_W(4)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    always #5 clk = ~clk;

    obs_t obs1, obs3;
    assign obs1 = {bus1.busy, bus1.done, bus1.err, bus1.mem_wr, bus1.mdr_load, bus1.sh_sel, bus1.mem_addr};
    assign obs3 = {bus3.busy, bus3.done, bus3.err, bus3.mem_wr, bus3.mdr_load, bus3.sh_sel, bus3.mem_addr};

    always @(negedge clk) begin
        if ((bus1.mem_wr && bus1.mdr_load) || (bus3.mem_wr && bus3.mdr_load))
            n_overlap++;
    end

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got busy=%b done=%b err=%b wr=%b mdr=%b sel=%b addr=%h, want busy=%b done=%b err=%b wr=%b mdr=%b sel=%b addr=%h",
                     name, act.busy, act.done, act.err, act.mem_wr, act.mdr_load, act.sh_sel, act.mem_addr,
                     exp.busy, exp.done, exp.err, exp.mem_wr, exp.mdr_load, exp.sh_sel, exp.mem_addr);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Expected outputs k cycles after the accepting edge.
    // Phase codes: 0 idle, 1 read, 2 capture, 3 write, 4 finish, 5 error.
    function automatic obs_t expect_at(input vec_t v, input int lat, input int k);
        int   ph;
        obs_t e;
        ph = 0;
        if (v.illegal)
            ph = (k == 1) ? 5 : 0;
        else if (v.op == 3'b001)
            ph = (k == 1) ? 3 : (k == 2) ? 4 : 0;
        else if (k <= lat)
            ph = 1;
        else if (k == lat + 1)
            ph = (v.op == 3'b011 || v.op == 3'b100 || v.op == 3'b101) ? 2 : 3;
        else if (k == lat + 2)
            ph = 4;
        e = RST_OBS;
        if (ph != 0) begin
            e.busy     = 1'b1;
            e.mem_addr = v.word;
        end
        case (ph)
            2: begin e.mdr_load = 1'b1; e.sh_sel = v.op; end
            3: begin e.mem_wr   = 1'b1; e.sh_sel = v.op; end
            4: e.done = 1'b1;
            5: e.err  = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    initial begin
        int d1, d3, w1, w3, busy_after;

        //            op      addr           illegal word
        vecs[0]  = '{3'b100, 32'h0000_0010, 1'b0, 32'h0000_0010};  // lw
        vecs[1]  = '{3'b000, 32'h0000_0007, 1'b0, 32'h0000_0004};  // sb
        vecs[2]  = '{3'b001, 32'h0000_0008, 1'b0, 32'h0000_0008};  // sw
        vecs[3]  = '{3'b101, 32'h0000_0003, 1'b1, 32'h0000_0000};  // lh misaligned
        vecs[4]  = '{3'b110, 32'h0000_0000, 1'b1, 32'h0000_0000};  // unknown op
        vecs[5]  = '{3'b010, 32'h0000_0006, 1'b0, 32'h0000_0004};  // sh
        vecs[6]  = '{3'b011, 32'h0000_0005, 1'b0, 32'h0000_0004};  // lb
        vecs[7]  = '{3'b101, 32'h0000_0002, 1'b0, 32'h0000_0000};  // lh
        vecs[8]  = '{3'b001, 32'h0000_0002, 1'b1, 32'h0000_0000};  // sw misaligned
        vecs[9]  = '{3'b100, 32'h0000_0001, 1'b1, 32'h0000_0000};  // lw misaligned
        vecs[10] = '{3'b010, 32'h0000_0001, 1'b1, 32'h0000_0000};  // sh misaligned
        vecs[11] = '{3'b111, 32'h0000_0004, 1'b1, 32'h0000_0004};  // unknown op
        vecs[12] = '{3'b000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC};  // sb top byte
        vecs[13] = '{3'b100, 32'h8000_0004, 1'b0, 32'h8000_0004};  // lw high half

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_obs("reset L1", obs1, RST_OBS);
        check_obs("reset L3", obs3, RST_OBS);
        reset = 1'b0;
        @(negedge clk);
        check_obs("post-reset idle L1", obs1, RST_OBS);
        check_obs("post-reset idle L3", obs3, RST_OBS);

        // single requests, inputs scrambled right after acceptance
        for (int i = 0; i < NVEC; i++) begin
            start = 1'b1;
            op    = vecs[i].op;
            addr  = vecs[i].addr;
            @(negedge clk);
            start = 1'b0;
            op    = 3'b111;
            addr  = ~vecs[i].addr;
            for (int k = 1; k <= 6; k++) begin
                check_obs($sformatf("vec%0d L1 c%0d", i, k), obs1, expect_at(vecs[i], 1, k));
                check_obs($sformatf("vec%0d L3 c%0d", i, k), obs3, expect_at(vecs[i], 3, k));
                @(negedge clk);
            end
        end

        // start held high across sh requests: next accept only after done
        d1 = 0; d3 = 0; w1 = 0; w3 = 0;
        start = 1'b1;
        op    = 3'b010;
        addr  = 32'h0000_0022;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 7) begin
                d1 += int'(bus1.done);
                w1 += int'(bus1.mem_wr);
            end
            d3 += int'(bus3.done);
            w3 += int'(bus3.mem_wr);
            if (c == 4) check_int("held L1 idle gap busy", int'(bus1.busy), 0);
            if (c == 5) check_int("held L1 reaccept busy", int'(bus1.busy), 1);
            if (c == 6) check_int("held L3 idle gap busy", int'(bus3.busy), 0);
            if (c == 7) check_int("held L3 reaccept busy", int'(bus3.busy), 1);
            if (c == 7) check_int("held L1 second done", int'(bus1.done), 1);
            if (c == 11) check_int("held L3 second done", int'(bus3.done), 1);
        end
        start = 1'b0;
        check_int("held L1 done count", d1, 2);
        check_int("held L3 done count", d3, 2);
        check_int("held L1 write count", w1, 2);
        check_int("held L3 write count", w3, 2);
        repeat (3) @(negedge clk);
        check_obs("held drain L1", obs1, RST_OBS);
        check_obs("held drain L3", obs3, RST_OBS);

        // reset during the read phase of an sb
        start = 1'b1;
        op    = 3'b000;
        addr  = 32'h0000_0007;
        @(negedge clk);
        start = 1'b0;
        check_int("abort L1 in read", int'(bus1.busy), 1);
        check_int("abort L3 in read", int'(bus3.busy), 1);
        #2 reset = 1'b1;
        #1;
        check_obs("abort async L1", obs1, RST_OBS);
        check_obs("abort async L3", obs3, RST_OBS);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        w1 = 0; w3 = 0; busy_after = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            w1 += int'(bus1.mem_wr);
            w3 += int'(bus3.mem_wr);
            busy_after += int'(bus1.busy) + int'(bus3.busy);
        end
        check_int("abort L1 no write", w1, 0);
        check_int("abort L3 no write", w3, 0);
        check_int("abort stays idle", busy_after, 0);

        check_int("wr/mdr overlap cycles", n_overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
